bank_req_scheduler: RTL and testbench
=====================================

BANK_REQ_SCHEDULER -- requirements
Module: bank_req_scheduler

Interface
REQ-001 SHALL use parameter P from parameter.v, default 2; number of lanes, giving 2P requests and 2P banks.
REQ-002 SHALL use parameter MAP from parameter.v, default 2; width of one bank or request index, equal to log2(2P).
REQ-003 SHALL use parameter BI_PACK from parameter.v, default 8; packed index-bus width, equal to 2P*MAP.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: a new batch of 2P requests is offered.
REQ-007 SHALL have port in_ready, output, 1 bit: the scheduler accepts a batch this cycle.
REQ-008 SHALL have port req_BI_bus, input, BI_PACK bits: field j, bits [j*MAP +: MAP], is the target bank of request j.
REQ-009 SHALL have port stall, input, 1 bit: downstream hold; freezes the current serve cycle.
REQ-010 SHALL have port sel_BI_bus, output, BI_PACK bits: field k is the request index routed to bank k; this is the select bus of the bank-input crossbar.
REQ-011 SHALL have port bank_en_bus, output, 2P bits: bit k set means bank k is serviced this cycle.
REQ-012 SHALL have port grant_bus, output, 2P bits: bit j set means request j is serviced this cycle.
REQ-013 SHALL have port out_valid, output, 1 bit: sel_BI_bus, bank_en_bus and grant_bus are valid.
REQ-014 SHALL have port batch_done, output, 1 bit: single-cycle pulse in the final serve cycle of a batch.

Function
REQ-015 SHALL implement a two-state FSM with states IDLE and SERVE.
REQ-016 SHALL drive in_ready = 1 exactly when the state is IDLE.
REQ-017 SHALL, in IDLE when in_valid=1, capture req_BI_bus into an internal index register, set the pending mask to all ones, and enter SERVE on that edge.
REQ-018 SHALL make the first grants visible in the cycle after acceptance (latency 1).
REQ-019 SHALL, in SERVE, grant for each bank k the lowest-index pending request j whose captured index equals k (fixed priority).
REQ-020 SHALL, in SERVE, set sel_BI field k to that j and bank_en[k]=1 for each bank granted under REQ-019.
REQ-021 SHALL drive sel_BI field k = 0 and bank_en[k] = 0 for every bank with no pending request.
REQ-022 SHALL ensure at most one grant per bank per cycle, and that every request is granted exactly once per batch.
REQ-023 SHALL make the grant, sel and enable outputs combinational from the registered state, and assert out_valid exactly when the state is SERVE.
REQ-024 SHALL, on each SERVE edge with stall=0, clear the granted bits from the pending mask.
REQ-025 SHALL, on each SERVE edge with stall=1, leave the pending mask and all outputs unchanged.
REQ-026 SHALL assert batch_done when the state is SERVE, stall=0, and pending AND NOT grant equals 0.
REQ-027 SHALL return to IDLE on the clock edge that ends the batch_done cycle.
REQ-028 SHALL take a number of unstalled SERVE cycles equal to the maximum number of requests targeting any single bank, in the range 1 to 2P.
REQ-029 SHALL ignore in_valid while the state is SERVE; no capture occurs and the batch is not corrupted.
REQ-030 SHALL provide no back-to-back overlap: a new batch is accepted no earlier than the cycle after batch_done.

Reset
REQ-031 SHALL, on rst=1, immediately force state=IDLE, pending mask=0 and captured indices=0.
REQ-032 SHALL, on rst=1, force out_valid, batch_done, grant_bus, bank_en_bus and sel_BI_bus to 0, and in_ready to 1.
REQ-033 SHALL, when rst is asserted mid-batch, discard that batch.
REQ-034 SHALL grant nothing from a discarded batch after rst deasserts.

Verification (P=2, MAP=2; index lists give request 0..3)
REQ-035 Conflict-free: BI={3,2,1,0} -> one SERVE cycle with sel fields bank0..3 = {3,2,1,0}, bank_en=1111, grant=1111, batch_done=1.
REQ-036 Full conflict: BI={2,2,2,2} -> four SERVE cycles with sel field bank2 = 0,1,2,3 and bank_en=0100 each cycle; batch_done in the 4th cycle only.
REQ-037 Pairwise: BI={0,0,1,1} -> cycle 1: grant=0101, sel bank0=0, sel bank1=2; cycle 2: grant=1010, sel bank0=1, sel bank1=3; batch_done in cycle 2.
REQ-038 Stall: BI={2,2,2,2} with stall=1 for 3 cycles starting at the first SERVE cycle -> outputs held at sel bank2=0, seven SERVE cycles in total, grants still in order 0,1,2,3.
REQ-039 Busy and reset: in_valid=1 with BI={0,1,2,3} during the 2nd cycle of the full-conflict case -> ignored; then rst=1 in the 3rd cycle -> all outputs 0 without waiting for a clock edge, in_ready=1, and no further grants after release.

Source files
------------

// File: rtl/bank_req_scheduler_if.sv
// Handshake and crossbar-control bundle between a request source and the bank scheduler.
// The master drives batches and stall; the slave returns per-bank selects and grants.
interface bank_req_scheduler_if #(
  parameter int P       = 2,
  parameter int BI_PACK = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [BI_PACK-1:0] req_BI_bus;
  logic               stall;
  logic [BI_PACK-1:0] sel_BI_bus;
  logic [2*P-1:0]     bank_en_bus;
  logic [2*P-1:0]     grant_bus;
  logic               out_valid;
  logic               batch_done;

  modport master (
    output in_valid, req_BI_bus, stall,
    input  in_ready, sel_BI_bus, bank_en_bus, grant_bus, out_valid, batch_done
  );

  modport slave (
    input  in_valid, req_BI_bus, stall,
    output in_ready, sel_BI_bus, bank_en_bus, grant_bus, out_valid, batch_done
  );
endinterface

// File: rtl/bank_req_scheduler.sv
// Schedules a batch of 2P bank-targeted requests onto 2P banks, one request per bank
// per cycle, lowest request index first.
//   state | meaning
//   IDLE  | waiting for a batch, in_ready high
//   SERVE | granting pending requests until the batch drains
module bank_req_scheduler #(
  parameter int P       = 2,
  parameter int MAP     = 2,
  parameter int BI_PACK = 8
) (
  input logic                 clk,
  input logic                 rst,
  bank_req_scheduler_if.slave bus
);
  localparam int N = 2 * P;

  typedef enum logic {IDLE, SERVE} state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       pending_q, pending_d;
  logic [BI_PACK-1:0] idx_q, idx_d;

  logic [BI_PACK-1:0] sel;
  logic [N-1:0]       bank_en;
  logic [N-1:0]       grant;
  logic               batch_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
    end
  end

  // Descending scan so the lowest matching request index is the one left in sel.
  always_comb begin
    sel     = '0;
    bank_en = '0;
    grant   = '0;
    if (state_q == SERVE) begin
      for (int k = 0; k < N; k++) begin
        for (int j = N - 1; j >= 0; j--) begin
          if (pending_q[j] && (int'(idx_q[j*MAP +: MAP]) == k)) begin
            sel[k*MAP +: MAP] = MAP'(j);
            bank_en[k]        = 1'b1;
          end
        end
      end
      for (int j = 0; j < N; j++) begin
        grant[j] = pending_q[j] && bank_en[int'(idx_q[j*MAP +: MAP])] &&
                   (int'(sel[int'(idx_q[j*MAP +: MAP])*MAP +: MAP]) == j);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    idx_d      = idx_q;
    batch_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          idx_d     = bus.req_BI_bus;
          pending_d = '1;
          state_d   = SERVE;
        end
      end
      SERVE: begin
        if (!bus.stall) begin
          pending_d = pending_q & ~grant;
          if (pending_d == '0) begin
            batch_done = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == SERVE);
  assign bus.sel_BI_bus  = sel;
  assign bus.bank_en_bus = bank_en;
  assign bus.grant_bus   = grant;
  assign bus.batch_done  = batch_done;
endmodule

// File: tb/tb_bank_req_scheduler.sv
// Self-checking bench for bank_req_scheduler (P=2, MAP=2): directed scenarios plus
// randomized batches compared against a per-bank FIFO-order reference model.
module tb_bank_req_scheduler;
  logic clk;
  logic rst;
  int   checks;
  int   passes;

  bank_req_scheduler_if #(.P(2), .BI_PACK(8)) bus ();

  bank_req_scheduler #(.P(2), .MAP(2), .BI_PACK(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank k serves its requests in ascending index order, the c-th one in serve cycle c.
  function automatic void model(input logic [7:0] bi, input int c,
                                output logic [7:0] e_sel, output logic [3:0] e_en,
                                output logic [3:0] e_grant, output int maxc);
    int cnt[4];
    int k;
    e_sel   = '0;
    e_en    = '0;
    e_grant = '0;
    maxc    = 0;
    for (int b = 0; b < 4; b++) cnt[b] = 0;
    for (int j = 0; j < 4; j++) begin
      k = int'(bi[j*2 +: 2]);
      if (cnt[k] == c) begin
        e_grant[j]       = 1'b1;
        e_en[k]          = 1'b1;
        e_sel[k*2 +: 2]  = 2'(j);
      end
      cnt[k]++;
    end
    for (int b = 0; b < 4; b++) if (cnt[b] > maxc) maxc = cnt[b];
  endfunction

  // Entered and left at posedge+1; checks every serve cycle against the model.
  task automatic run_batch(input logic [7:0] bi, input logic [31:0] stall_mask,
                           input string name, output int total);
    logic [7:0] e_sel;
    logic [3:0] e_en, e_grant;
    int         maxc;
    int         c;
    logic       e_done;
    c     = 0;
    total = 0;
    model(bi, 0, e_sel, e_en, e_grant, maxc);
    bus.in_valid   = 1'b1;
    bus.req_BI_bus = bi;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1)
      $display("FAIL %s accept_ready: got %b want 1", name, bus.in_ready);
    else passes++;
    @(posedge clk); #1;
    bus.in_valid   = 1'b0;
    bus.req_BI_bus = $urandom;
    while (c < maxc && total < 40) begin
      bus.stall = stall_mask[total];
      model(bi, c, e_sel, e_en, e_grant, maxc);
      e_done = !bus.stall && (c == maxc - 1);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.sel_BI_bus !== e_sel || bus.bank_en_bus !== e_en ||
          bus.grant_bus !== e_grant || bus.batch_done !== e_done)
        $display("FAIL %s cycle%0d: got v=%b rdy=%b sel=%h en=%b gr=%b done=%b want v=1 rdy=0 sel=%h en=%b gr=%b done=%b",
                 name, total, bus.out_valid, bus.in_ready, bus.sel_BI_bus, bus.bank_en_bus,
                 bus.grant_bus, bus.batch_done, e_sel, e_en, e_grant, e_done);
      else passes++;
      if (!bus.stall) c++;
      total++;
      @(posedge clk); #1;
    end
    bus.stall = 1'b0;
    checks++;
    if (total >= 40)
      $display("FAIL %s timeout: got %0d cycles want < 40", name, total);
    else passes++;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.grant_bus !== 4'b0)
      $display("FAIL %s after_done: got v=%b rdy=%b gr=%b want v=0 rdy=1 gr=0000",
               name, bus.out_valid, bus.in_ready, bus.grant_bus);
    else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.batch_done !== 1'b0 ||
        bus.grant_bus !== 4'b0 || bus.bank_en_bus !== 4'b0 || bus.sel_BI_bus !== 8'h0)
      $display("FAIL reset_state: got rdy=%b v=%b done=%b gr=%b en=%b sel=%h want 1 0 0 0000 0000 00",
               bus.in_ready, bus.out_valid, bus.batch_done, bus.grant_bus,
               bus.bank_en_bus, bus.sel_BI_bus);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_conflict_free();
    bus.in_valid   = 1'b1;
    bus.req_BI_bus = 8'h1B;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.sel_BI_bus !== 8'h1B || bus.bank_en_bus !== 4'hF || bus.grant_bus !== 4'hF ||
        bus.batch_done !== 1'b1 || bus.out_valid !== 1'b1)
      $display("FAIL conflict_free: got sel=%h en=%b gr=%b done=%b v=%b want 1b 1111 1111 1 1",
               bus.sel_BI_bus, bus.bank_en_bus, bus.grant_bus, bus.batch_done, bus.out_valid);
    else passes++;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL conflict_free_end: got v=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
    else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_full_conflict();
    int total;
    run_batch(8'hAA, 32'h0, "full_conflict", total);
    checks++;
    if (total !== 4) $display("FAIL full_conflict_cycles: got %0d want 4", total);
    else passes++;
  endtask

  task automatic test_pairwise();
    int total;
    run_batch(8'h50, 32'h0, "pairwise", total);
    checks++;
    if (total !== 2) $display("FAIL pairwise_cycles: got %0d want 2", total);
    else passes++;
  endtask

  task automatic test_stall();
    int total;
    run_batch(8'hAA, 32'h7, "stall", total);
    checks++;
    if (total !== 7) $display("FAIL stall_cycles: got %0d want 7", total);
    else passes++;
  endtask

  task automatic test_busy_reset();
    bus.in_valid   = 1'b1;
    bus.req_BI_bus = 8'hAA;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.grant_bus !== 4'b0001 || bus.sel_BI_bus[5:4] !== 2'd0)
      $display("FAIL busy_c1: got gr=%b sel2=%0d want 0001 0", bus.grant_bus, bus.sel_BI_bus[5:4]);
    else passes++;
    @(posedge clk); #1;
    bus.in_valid   = 1'b1;
    bus.req_BI_bus = 8'hE4;
    @(negedge clk);
    checks++;
    if (bus.grant_bus !== 4'b0010 || bus.in_ready !== 1'b0 || bus.sel_BI_bus[5:4] !== 2'd1)
      $display("FAIL busy_c2: got gr=%b rdy=%b sel2=%0d want 0010 0 1",
               bus.grant_bus, bus.in_ready, bus.sel_BI_bus[5:4]);
    else passes++;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.grant_bus !== 4'b0100 || bus.bank_en_bus !== 4'b0100)
      $display("FAIL busy_ignored: got gr=%b en=%b want 0100 0100", bus.grant_bus, bus.bank_en_bus);
    else passes++;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.batch_done !== 1'b0 || bus.grant_bus !== 4'b0 ||
        bus.bank_en_bus !== 4'b0 || bus.sel_BI_bus !== 8'h0 || bus.in_ready !== 1'b1)
      $display("FAIL async_reset: got v=%b done=%b gr=%b en=%b sel=%h rdy=%b want 0 0 0000 0000 00 1",
               bus.out_valid, bus.batch_done, bus.grant_bus, bus.bank_en_bus,
               bus.sel_BI_bus, bus.in_ready);
    else passes++;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.grant_bus !== 4'b0)
        $display("FAIL discarded_%0d: got v=%b gr=%b want 0 0000", i, bus.out_valid, bus.grant_bus);
      else passes++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int total;
    logic [7:0]  bi;
    logic [31:0] sm;
    for (int n = 0; n < 40; n++) begin
      bi = 8'($urandom);
      sm = $urandom & $urandom;
      run_batch(bi, sm, $sformatf("random%0d", n), total);
    end
  endtask

  initial begin
    checks         = 0;
    passes         = 0;
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.req_BI_bus = 8'h0;
    bus.stall      = 1'b0;
    test_reset();
    test_conflict_free();
    test_full_conflict();
    test_pairwise();
    test_stall();
    test_busy_reset();
    test_full_conflict();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
